// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM state encodings and reserved-opcode range
// shared by alu_multicycle and its iterative multiply/divide helper.
// MUL/DIV only execute when the design is built with ALU_MULDIV_EN.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SHL = 4'b0010;
    localparam logic [3:0] ALU_SHR = 4'b0011;
    localparam logic [3:0] ALU_MOV = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;

    // Opcodes in this range complete in one cycle with a zero result.
    localparam logic [3:0] ALU_RSV_LO = 4'b1010;
    localparam logic [3:0] ALU_RSV_HI = 4'b1111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ITER   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    function automatic logic is_reserved(input logic [3:0] op);
        return (op >= ALU_RSV_LO) && (op <= ALU_RSV_HI);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier and
// restoring divider. Loaded with the operands, then stepped DATA_WIDTH times.
// The *_nxt outputs are the values after the current step, so the parent can
// capture the final result on the same edge as the last step.
// Only instantiated when ALU_MULDIV_EN is defined.
module alu_muldiv_iter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  is_div_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] lo_nxt_o,
    output logic [DATA_WIDTH-1:0] hi_nxt_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [CW-1:0] cnt_q;
    logic          div_q;
    // acc_q: product high half / partial remainder; lo_q: multiplier / quotient
    logic [W-1:0]  acc_q;
    logic [W-1:0]  lo_q;
    logic [W-1:0]  b_q;

    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_trial;

    // One iteration: conditional add then shift right (MUL), or shift left
    // and trial-subtract, keeping the difference only when it does not borrow (DIV).
    always_comb begin
        mul_sum   = lo_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
        div_shift = {acc_q, lo_q[W-1]};
        div_trial = div_shift - {1'b0, b_q};
        if (div_q) begin
            if (!div_trial[W]) begin
                hi_nxt_o = div_trial[W-1:0];
                lo_nxt_o = {lo_q[W-2:0], 1'b1};
            end else begin
                hi_nxt_o = div_shift[W-1:0];
                lo_nxt_o = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            hi_nxt_o = mul_sum[W:1];
            lo_nxt_o = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    // Step counter and operation select; cleared by reset so an aborted op leaves nothing behind.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= CW'(W);
            div_q <= is_div_i;
        end else if (step_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Datapath registers; always reloaded before use, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            acc_q <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
        end else if (step_i) begin
            acc_q <= hi_nxt_o;
            lo_q  <= lo_nxt_o;
        end
    end

    assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with start/busy/done handshake, registered
// zero/carry/negative/overflow flags and a high-half result port.
// Build option ALU_MULDIV_EN: adds iterative unsigned MUL/DIV (DATA_WIDTH
// cycles each). Without it, MUL/DIV opcodes behave like reserved opcodes.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int SELECT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SELECT_WIDTH-1:0] select,
    input  logic [DATA_WIDTH-1:0]   reg_a,
    input  logic [DATA_WIDTH-1:0]   reg_b,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   out,
    output logic [DATA_WIDTH-1:0]   out_hi,
    output logic                    zero_flag,
    output logic                    carrier_flag,
    output logic                    negative_flag,
    output logic                    overflow_flag
);

    localparam int W = DATA_WIDTH;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] hi_q, hi_d;
    logic         zf_q, zf_d;
    logic         cf_q, cf_d;
    logic         nf_q, nf_d;
    logic         vf_q, vf_d;

    logic [3:0]   op;
    assign op = select[3:0];

    logic [W:0]   sc_wide;
    logic [W-1:0] sc_res;
    logic         sc_c, sc_n, sc_v;

    // Single-cycle result and flags; shifts use one spare bit to catch the last bit shifted out.
    always_comb begin
        sc_wide = '0;
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_n    = 1'b0;
        sc_v    = 1'b0;
        if (!is_reserved(op)) begin
            case (op)
                ALU_ADD: begin
                    sc_wide = {1'b0, reg_a} + {1'b0, reg_b};
                    sc_res  = sc_wide[W-1:0];
                    sc_c    = sc_wide[W];
                    sc_n    = sc_res[W-1];
                    sc_v    = (reg_a[W-1] == reg_b[W-1]) && (sc_res[W-1] != reg_a[W-1]);
                end
                ALU_SUB: begin
                    sc_wide = {1'b0, reg_a} - {1'b0, reg_b};
                    sc_res  = sc_wide[W-1:0];
                    sc_c    = sc_wide[W];
                    sc_n    = sc_wide[W];
                    sc_v    = (reg_a[W-1] != reg_b[W-1]) && (sc_res[W-1] != reg_a[W-1]);
                end
                ALU_SHL: begin
                    sc_wide = {1'b0, reg_a} << reg_b;
                    sc_res  = sc_wide[W-1:0];
                    sc_c    = sc_wide[W];
                    sc_n    = sc_res[W-1];
                end
                ALU_SHR: begin
                    sc_wide = {reg_a, 1'b0} >> reg_b;
                    sc_res  = sc_wide[W:1];
                    sc_c    = sc_wide[0];
                    sc_n    = sc_res[W-1];
                end
                ALU_MOV: begin
                    sc_res = reg_b;
                    sc_n   = sc_res[W-1];
                end
                ALU_AND: begin
                    sc_res = reg_a & reg_b;
                    sc_n   = sc_res[W-1];
                end
                ALU_OR: begin
                    sc_res = reg_a | reg_b;
                    sc_n   = sc_res[W-1];
                end
                ALU_XOR: begin
                    sc_res = reg_a ^ reg_b;
                    sc_n   = sc_res[W-1];
                end
                default: begin
                    sc_res = '0;
                end
            endcase
        end
    end

`ifdef ALU_MULDIV_EN
    logic         md_load, md_step, md_last;
    logic [W-1:0] md_lo, md_hi;
    logic         is_div_q, div0_q;

    alu_muldiv_iter #(
        .DATA_WIDTH(W)
    ) u_iter (
        .clk_i    (clk),
        .reset_i  (reset),
        .load_i   (md_load),
        .step_i   (md_step),
        .is_div_i (op == ALU_DIV),
        .a_i      (reg_a),
        .b_i      (reg_b),
        .last_o   (md_last),
        .lo_nxt_o (md_lo),
        .hi_nxt_o (md_hi)
    );

    // Remember which iterative op is running and whether it divides by zero, for the carry flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else if (md_load) begin
            is_div_q <= (op == ALU_DIV);
            div0_q   <= (reg_b == '0);
        end
    end
`endif

    // Handshake FSM; results and flags are loaded only on the transition into FINISH.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        hi_d    = hi_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        nf_d    = nf_q;
        vf_d    = vf_q;
`ifdef ALU_MULDIV_EN
        md_load = 1'b0;
        md_step = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef ALU_MULDIV_EN
                    if ((op == ALU_MUL) || (op == ALU_DIV)) begin
                        md_load = 1'b1;
                        state_d = ST_ITER;
                    end else
`endif
                    begin
                        state_d = ST_FINISH;
                        out_d   = sc_res;
                        hi_d    = '0;
                        zf_d    = (sc_res == '0);
                        cf_d    = sc_c;
                        nf_d    = sc_n;
                        vf_d    = sc_v;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            ST_ITER: begin
                md_step = 1'b1;
                if (md_last) begin
                    state_d = ST_FINISH;
                    out_d   = md_lo;
                    hi_d    = md_hi;
                    zf_d    = (md_lo == '0);
                    cf_d    = is_div_q ? div0_q : (md_hi != '0);
                    nf_d    = md_lo[W-1];
                    vf_d    = 1'b0;
                end
            end
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            hi_q    <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            nf_q    <= 1'b0;
            vf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            nf_q    <= nf_d;
            vf_q    <= vf_d;
        end
    end

    assign busy          = (state_q == ST_ITER);
    assign done          = (state_q == ST_FINISH);
    assign out           = out_q;
    assign out_hi        = hi_q;
    assign zero_flag     = zf_q;
    assign carrier_flag  = cf_q;
    assign negative_flag = nf_q;
    assign overflow_flag = vf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (DATA_WIDTH=8). Iterative MUL/DIV vectors
// apply when ALU_MULDIV_EN is defined; otherwise those opcodes are expected
// to behave as reserved opcodes.
module tb_alu_multicycle;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] select;
    logic [7:0] reg_a, reg_b;
    logic       busy, done;
    logic [7:0] out, out_hi;
    logic       zero_flag, carrier_flag, negative_flag, overflow_flag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_multicycle #(
        .DATA_WIDTH   (8),
        .SELECT_WIDTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .select        (select),
        .reg_a         (reg_a),
        .reg_b         (reg_b),
        .busy          (busy),
        .done          (done),
        .out           (out),
        .out_hi        (out_hi),
        .zero_flag     (zero_flag),
        .carrier_flag  (carrier_flag),
        .negative_flag (negative_flag),
        .overflow_flag (overflow_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one op; lat counts edges from the accepting edge to the first done sample.
    task automatic launch(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        select = sel;
        reg_a  = a;
        reg_b  = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full op with checks on latency, results and packed {zero,carry,neg,ovf} flags.
    task automatic run_op(input string tag, input logic [3:0] sel, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_out,
                          input logic [7:0] exp_hi, input logic [3:0] exp_flags,
                          input int exp_lat);
        int lat, bc;
        launch(sel, a, b, lat, bc);
        chk({tag, "_lat"},   lat, exp_lat);
        chk({tag, "_done"},  done, 1'b1);
        chk({tag, "_out"},   out, exp_out);
        chk({tag, "_hi"},    out_hi, exp_hi);
        chk({tag, "_flags"}, {zero_flag, carrier_flag, negative_flag, overflow_flag}, exp_flags);
        chk({tag, "_busy"},  bc, exp_lat - 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, bc, done_seen;
        reset  = 1'b1;
        start  = 1'b0;
        select = 4'h0;
        reg_a  = 8'h00;
        reg_b  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl",  {busy, done}, 2'b00);
        chk("rst_out",  {out, out_hi}, 16'h0000);
        chk("rst_flag", {zero_flag, carrier_flag, negative_flag, overflow_flag}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        run_op("add_carry", 4'b0000, 8'd200, 8'd100, 8'h2C, 8'h00, 4'b0100, 1);
        run_op("add_ovf",   4'b0000, 8'd100, 8'd100, 8'hC8, 8'h00, 4'b0011, 1);
        run_op("sub_neg",   4'b0001, 8'd5,   8'd9,   8'hFC, 8'h00, 4'b0110, 1);
        run_op("sub_zero",  4'b0001, 8'd7,   8'd7,   8'h00, 8'h00, 4'b1000, 1);
        run_op("sub_sovf",  4'b0001, 8'h80,  8'h01,  8'h7F, 8'h00, 4'b0001, 1);
        run_op("shl_1",     4'b0010, 8'h81,  8'd1,   8'h02, 8'h00, 4'b0100, 1);
        run_op("shl_w",     4'b0010, 8'h01,  8'd8,   8'h00, 8'h00, 4'b1100, 1);
        run_op("shl_0",     4'b0010, 8'h81,  8'd0,   8'h81, 8'h00, 4'b0010, 1);
        run_op("shr_1",     4'b0011, 8'h81,  8'd1,   8'h40, 8'h00, 4'b0100, 1);
        run_op("shr_9",     4'b0011, 8'hFF,  8'd9,   8'h00, 8'h00, 4'b1000, 1);
        run_op("mov",       4'b0100, 8'h11,  8'h80,  8'h80, 8'h00, 4'b0010, 1);
        run_op("and",       4'b0101, 8'hF0,  8'h3C,  8'h30, 8'h00, 4'b0000, 1);
        run_op("or",        4'b0110, 8'h80,  8'h01,  8'h81, 8'h00, 4'b0010, 1);
        run_op("xor",       4'b0111, 8'hF0,  8'hFF,  8'h0F, 8'h00, 4'b0000, 1);
        run_op("rsv_1100",  4'b1100, 8'd5,   8'd3,   8'h00, 8'h00, 4'b1000, 1);

`ifdef ALU_MULDIV_EN
        run_op("mul_200x3", 4'b1000, 8'd200, 8'd3,  8'h58, 8'h02, 4'b0100, 9);
        run_op("mul_13x11", 4'b1000, 8'd13,  8'd11, 8'h8F, 8'h00, 4'b0010, 9);
        run_op("div_200_7", 4'b1001, 8'd200, 8'd7,  8'd28, 8'd4,  4'b0000, 9);
        run_op("div_9_0",   4'b1001, 8'd9,   8'd0,  8'hFF, 8'd9,  4'b0110, 9);

        // start pulsed while busy must be ignored
        @(negedge clk);
        select = 4'b1000; reg_a = 8'd13; reg_b = 8'd11; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        @(negedge clk);
        select = 4'b0000; reg_a = 8'd1; reg_b = 8'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ign_lat", lat, 9);
        chk("ign_out", {out_hi, out}, 16'h008F);
        done_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("ign_nodone", done_seen, 0);
        chk("ign_hold", out, 8'h8F);
`else
        run_op("mul_rsv",   4'b1000, 8'd200, 8'd3,  8'h00, 8'h00, 4'b1000, 1);
        run_op("div_rsv",   4'b1001, 8'd9,   8'd0,  8'h00, 8'h00, 4'b1000, 1);
`endif

        // Reset in flight: leave non-zero results, then reset mid-operation
        run_op("pre_rst", 4'b0000, 8'd200, 8'd100, 8'h2C, 8'h00, 4'b0100, 1);
`ifdef ALU_MULDIV_EN
        @(negedge clk);
        select = 4'b1000; reg_a = 8'd200; reg_b = 8'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        chk("mid_busy", busy, 1'b1);
`else
        @(posedge clk);
`endif
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ctl",  {busy, done}, 2'b00);
        chk("arst_out",  {out, out_hi}, 16'h0000);
        chk("arst_flag", {zero_flag, carrier_flag, negative_flag, overflow_flag}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", 4'b0000, 8'd100, 8'd100, 8'hC8, 8'h00, 4'b0011, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Registered, parametrised successor to the accumulator datapath's combinational ALU.
- Adds start/busy/done handshake, registered flags, a signed-overflow flag, and a high-half result port.
- Adds iterative MUL and DIV ops that take DATA_WIDTH cycles; all other ops complete in one cycle.
- Sits between the accumulator/operand registers and the writeback mux; the control FSM stalls on busy.

Parameters:
- DATA_WIDTH, 8, operand/result width (>=4).
- SELECT_WIDTH, 4, opcode width (fixed 4; 16 encodings).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch op; sampled only in IDLE.
- select  input  SELECT_WIDTH  opcode, latched at start.
- reg_a  input  DATA_WIDTH  operand A, latched at start.
- reg_b  input  DATA_WIDTH  operand B, latched at start.
- busy  output  1  high from cycle after accepted start until done.
- done  output  1  one-cycle pulse; results valid from that edge.
- out  output  DATA_WIDTH  result / product low / quotient.
- out_hi  output  DATA_WIDTH  product high / remainder; 0 for other ops.
- zero_flag, carrier_flag, negative_flag, overflow_flag  output  1 each  registered flags.

Behaviour:
- Reset (async, any state, including mid MUL/DIV): state IDLE; busy, done, out, out_hi and all flags = 0; the in-flight op is discarded.
- FSM states: IDLE, ITER, FINISH.
  - IDLE & start & single-cycle op -> FINISH; results registered at the same edge.
  - IDLE & start & MUL/DIV -> ITER; counter = DATA_WIDTH.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; at counter==1 -> FINISH.
  - FINISH: done=1 for that cycle only -> IDLE.
- start is ignored in ITER and FINISH (no queueing).
- Latency: start accepted at edge t -> done at t+1 for single-cycle ops, t+DATA_WIDTH+1 for MUL/DIV.
- out, out_hi and flags update only when entering FINISH and hold until the next completion.
- Opcodes (package constants):
  - 0000 ADD: {carry,out}=a+b.
  - 0001 SUB: out=a-b; carry=borrow (a<b); negative=(b>a) unsigned.
  - 0010 SHL and 0011 SHR: shift by b. For b in 1..W, carry = last bit shifted out. For b=0 or b>W, carry=0. For b>=W, out=0.
  - 0100 MOV: out=b.
  - 0101 AND, 0110 OR, 0111 XOR: carry=0.
  - 1000 MUL (unsigned): {out_hi,out}=a*b; carry=(out_hi!=0).
  - 1001 DIV (unsigned): out=a/b, out_hi=a%b. If b==0: out=all ones, out_hi=a, carry=1; still takes full latency.
  - 1010-1111 reserved: single-cycle; out=out_hi=0; zero=1; other flags 0.
- zero_flag = (out==0), out_hi ignored.
- negative_flag: MSB of out, except SUB as above.
- overflow_flag: two's-complement overflow for ADD/SUB; 0 otherwise.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: MUL/DIV as above, ITER state present.
- Undefined: no iterative datapath. 1000/1001 behave as reserved opcodes (single-cycle, out=0, zero=1). ITER is unreachable and may be omitted.

Decomposition:
- Package alu_pkg: opcode constants ALU_ADD..ALU_DIV, state encodings (IDLE/ITER/FINISH), reserved-opcode range.
- Sub-module alu_muldiv_iter: shift-add/restoring divider with load, step counter and last-step indication.
  - Instantiated only under ALU_MULDIV_EN.
  - Parent owns the FSM, flags and handshake.

Test Plan (DATA_WIDTH=8):
- ADD 200+100 -> done at t+1; out=0x2C, carry=1, overflow=0. ADD 100+100 -> out=0xC8, overflow=1, negative=1, carry=0.
- SUB 5-9 -> out=0xFC, carry=1, negative=1, zero=0. SUB 7-7 -> out=0, zero=1.
- MUL 200*3 -> busy for 8 cycles, done at t+9; out=0x58, out_hi=0x02, carry=1. MUL 13*11 -> out=0x8F, out_hi=0, carry=0.
- DIV 200/7 -> out=28, out_hi=4. DIV 9/0 -> out=0xFF, out_hi=9, carry=1, done at t+9.
- start pulsed while busy -> ignored, results unchanged. Reset asserted at iteration 4 of MUL -> all outputs 0 immediately; a new ADD then completes normally.
- SHL 0x81<<1 -> out=0x02, carry=1. SHR by 9 -> out=0, carry=0, zero=1. Opcode 1100 -> out=0, zero=1.
